// File: rtl/dist_sort_host.sv
// dist_sort_host: initiator/host for the 8-way distance sorter.
// The host owns the 8-entry search bank and takes one tagged query at a time.
// It drives the sorter, captures the two best-match addresses and returns a
// tagged result downstream. A watchdog aborts a query whose out_valid never
// arrives, or whose out_valid never drops.
// Optional build macro DIST_SORT_HOST_STATS_EN adds saturating statistics
// counters on the outputs stat_done, stat_timeout and stat_spurious.
module dist_sort_host #(
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 32,
    parameter int unsigned TMR_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [63:0]      wr_data,
    output logic             wr_err,
    input  logic             q_valid,
    output logic             q_ready,
    input  logic [63:0]      q_data,
    input  logic [TAG_W-1:0] q_tag,
    output logic [63:0]      query,
    output logic [63:0]      search_0,
    output logic [63:0]      search_1,
    output logic [63:0]      search_2,
    output logic [63:0]      search_3,
    output logic [63:0]      search_4,
    output logic [63:0]      search_5,
    output logic [63:0]      search_6,
    output logic [63:0]      search_7,
    output logic             in_valid,
    input  logic [2:0]       addr_1st,
    input  logic [2:0]       addr_2nd,
    input  logic             out_valid,
    output logic             r_valid,
    input  logic             r_ready,
    output logic [TAG_W-1:0] r_tag,
    output logic [2:0]       r_addr_1st,
    output logic [2:0]       r_addr_2nd,
    output logic             r_timeout,
    output logic             busy
`ifdef DIST_SORT_HOST_STATS_EN
    ,
    output logic [15:0]      stat_done,
    output logic [15:0]      stat_timeout,
    output logic [15:0]      stat_spurious
`endif
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned N_ENT  = 8;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              state, state_d;
    logic [TMR_W-1:0]    timer, timer_d;
    logic [TAG_W-1:0]    tag, tag_d;
    logic [DATA_W-1:0]   query_d;
    logic                in_valid_d;
    logic                r_valid_d;
    logic [TAG_W-1:0]    r_tag_d;
    logic [2:0]          r_addr_1st_d, r_addr_2nd_d;
    logic                r_timeout_d;
    logic                q_ready_d, busy_d, wr_err_d;
    logic [DATA_W-1:0]   bank [N_ENT];

    // Search vectors come straight from the bank registers.
    assign search_0 = bank[0];
    assign search_1 = bank[1];
    assign search_2 = bank[2];
    assign search_3 = bank[3];
    assign search_4 = bank[4];
    assign search_5 = bank[5];
    assign search_6 = bank[6];
    assign search_7 = bank[7];

    // Next-state and next-output logic of the query FSM.
    always_comb begin
        state_d      = state;
        timer_d      = timer;
        tag_d        = tag;
        query_d      = query;
        in_valid_d   = in_valid;
        r_valid_d    = r_valid;
        r_tag_d      = r_tag;
        r_addr_1st_d = r_addr_1st;
        r_addr_2nd_d = r_addr_2nd;
        r_timeout_d  = r_timeout;
        unique case (state)
            ST_IDLE: begin
                if (q_valid && q_ready) begin
                    query_d    = q_data;
                    tag_d      = q_tag;
                    timer_d    = '0;
                    in_valid_d = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (out_valid) begin
                    r_addr_1st_d = addr_1st;
                    r_addr_2nd_d = addr_2nd;
                    r_timeout_d  = 1'b0;
                    in_valid_d   = 1'b0;
                    timer_d      = '0;
                    state_d      = ST_DRAIN;
                end else if (timer == TMR_LAST) begin
                    r_addr_1st_d = '0;
                    r_addr_2nd_d = '0;
                    r_timeout_d  = 1'b1;
                    in_valid_d   = 1'b0;
                    timer_d      = '0;
                    state_d      = ST_DRAIN;
                end else begin
                    timer_d = timer + TMR_W'(1);
                end
            end
            ST_DRAIN: begin
                if (!out_valid) begin
                    r_valid_d = 1'b1;
                    r_tag_d   = tag;
                    state_d   = ST_RESP;
                end else if (timer == TMR_LAST) begin
                    r_timeout_d = 1'b1;
                    r_valid_d   = 1'b1;
                    r_tag_d     = tag;
                    state_d     = ST_RESP;
                end else begin
                    timer_d = timer + TMR_W'(1);
                end
            end
            ST_RESP: begin
                if (r_ready) begin
                    r_valid_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        q_ready_d = (state_d == ST_IDLE);
        busy_d    = (state_d != ST_IDLE);
        wr_err_d  = wr_en && (state != ST_IDLE);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            timer      <= '0;
            tag        <= '0;
            query      <= '0;
            in_valid   <= 1'b0;
            r_valid    <= 1'b0;
            r_tag      <= '0;
            r_addr_1st <= '0;
            r_addr_2nd <= '0;
            r_timeout  <= 1'b0;
            q_ready    <= 1'b1;
            busy       <= 1'b0;
            wr_err     <= 1'b0;
        end else begin
            state      <= state_d;
            timer      <= timer_d;
            tag        <= tag_d;
            query      <= query_d;
            in_valid   <= in_valid_d;
            r_valid    <= r_valid_d;
            r_tag      <= r_tag_d;
            r_addr_1st <= r_addr_1st_d;
            r_addr_2nd <= r_addr_2nd_d;
            r_timeout  <= r_timeout_d;
            q_ready    <= q_ready_d;
            busy       <= busy_d;
            wr_err     <= wr_err_d;
        end
    end

    // Search bank: writable only while idle so the sorter sees stable vectors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ENT; i++) bank[i] <= '0;
        end else if (wr_en && (state == ST_IDLE)) begin
            bank[wr_addr] <= wr_data;
        end
    end

`ifdef DIST_SORT_HOST_STATS_EN
    // Saturating counters for completed, timed-out and spurious events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_done     <= '0;
            stat_timeout  <= '0;
            stat_spurious <= '0;
        end else begin
            if ((state == ST_RESP) && r_ready && (stat_done != 16'hFFFF))
                stat_done <= stat_done + 16'd1;
            if ((state == ST_RESP) && r_ready && r_timeout && (stat_timeout != 16'hFFFF))
                stat_timeout <= stat_timeout + 16'd1;
            if ((state == ST_IDLE) && out_valid && (stat_spurious != 16'hFFFF))
                stat_spurious <= stat_spurious + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dist_sort_host.sv
// Testbench for dist_sort_host: directed scenarios plus randomized queries
// against a cycle-count reference model of the host and a behavioural sorter.
module tb_dist_sort_host;

    localparam int unsigned TAG_W   = 4;
    localparam int unsigned TIMEOUT = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [63:0] wr_data;
    logic        wr_err;
    logic        q_valid;
    logic        q_ready;
    logic [63:0] q_data;
    logic [TAG_W-1:0] q_tag;
    logic [63:0] query;
    logic [63:0] search_0, search_1, search_2, search_3;
    logic [63:0] search_4, search_5, search_6, search_7;
    logic        in_valid;
    logic [2:0]  addr_1st, addr_2nd;
    logic        out_valid;
    logic        r_valid;
    logic        r_ready;
    logic [TAG_W-1:0] r_tag;
    logic [2:0]  r_addr_1st, r_addr_2nd;
    logic        r_timeout;
    logic        busy;
`ifdef DIST_SORT_HOST_STATS_EN
    logic [15:0] stat_done, stat_timeout, stat_spurious;
    int exp_done = 0, exp_tmo = 0, exp_spur = 0;
`endif

    int n_checks = 0;
    int n_errs   = 0;
    logic [63:0] bank_m [8];

    // Behavioural sorter: answers sv_lat cycles after in_valid rises,
    // holding out_valid for sv_w cycles; sv_lat==0 means never answer.
    int          sv_lat = 0, sv_w = 1;
    logic [2:0]  sv_a1 = '0, sv_a2 = '0;
    bit          spur_req = 1'b0;

    dist_sort_host #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT), .TMR_W(8)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
        .q_valid(q_valid), .q_ready(q_ready), .q_data(q_data), .q_tag(q_tag),
        .query(query),
        .search_0(search_0), .search_1(search_1), .search_2(search_2), .search_3(search_3),
        .search_4(search_4), .search_5(search_5), .search_6(search_6), .search_7(search_7),
        .in_valid(in_valid), .addr_1st(addr_1st), .addr_2nd(addr_2nd), .out_valid(out_valid),
        .r_valid(r_valid), .r_ready(r_ready), .r_tag(r_tag),
        .r_addr_1st(r_addr_1st), .r_addr_2nd(r_addr_2nd), .r_timeout(r_timeout),
        .busy(busy)
`ifdef DIST_SORT_HOST_STATS_EN
        , .stat_done(stat_done), .stat_timeout(stat_timeout), .stat_spurious(stat_spurious)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_bank(input string name);
        logic [63:0] s [8];
        s[0] = search_0; s[1] = search_1; s[2] = search_2; s[3] = search_3;
        s[4] = search_4; s[5] = search_5; s[6] = search_6; s[7] = search_7;
        for (int k = 0; k < 8; k++) check($sformatf("%s_search_%0d", name, k), s[k], bank_m[k]);
    endtask

    // Sorter model: outputs change on the falling edge. The address lines
    // carry the answer only on the first out_valid cycle, garbage otherwise.
    initial begin
        int n, ov_left;
        bit first;
        n = 0; ov_left = 0;
        out_valid = 1'b0; addr_1st = '0; addr_2nd = '0;
        forever begin
            @(negedge clk);
            if (in_valid) n++; else n = 0;
            if (in_valid && sv_lat != 0 && n == sv_lat) ov_left = sv_w;
            if (spur_req) begin ov_left = 1; spur_req = 1'b0; end
            first = (ov_left == sv_w) && in_valid;
            if (ov_left > 0) begin out_valid = 1'b1; ov_left--; end
            else out_valid = 1'b0;
            addr_1st = first ? sv_a1 : ~sv_a1;
            addr_2nd = first ? sv_a2 : ~sv_a2;
        end
    end

    task automatic bank_write(input logic [2:0] a, input logic [63:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        bank_m[a] = d;
        check("idle_wr_err", 64'(wr_err), 64'd0);
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!q_ready && k < 100) begin @(negedge clk); k++; end
        check("q_ready_wait", 64'(q_ready), 64'd1);
    endtask

    // One full query with reference timing derived from the host's rules.
    task automatic run_query(input logic [TAG_W-1:0] tg, input int lat, input int w,
                             input logic [2:0] a1, input logic [2:0] a2, input int hold,
                             input bit wr_busy, input bit wr_acc, input logic [2:0] wa);
        logic [63:0] qd, wd;
        int lat_cnt, iv_cnt, exp_lat, exp_iv;
        bit exp_to;
        logic [2:0] e1, e2;
        if (lat >= 1 && lat <= int'(TIMEOUT)) begin
            exp_iv  = lat;
            exp_to  = (w - 1 >= int'(TIMEOUT));
            exp_lat = lat + (exp_to ? int'(TIMEOUT) : w);
            e1 = a1; e2 = a2;
        end else begin
            exp_iv = int'(TIMEOUT); exp_to = 1'b1; exp_lat = int'(TIMEOUT) + 1;
            e1 = '0; e2 = '0;
        end
        qd = {$urandom, $urandom};
        wd = {$urandom, $urandom};
        sv_lat = lat; sv_w = w; sv_a1 = a1; sv_a2 = a2;
        wait_ready();
        q_valid = 1'b1; q_data = qd; q_tag = tg;
        if (wr_acc) begin wr_en = 1'b1; wr_addr = wa; wr_data = wd; end
        @(negedge clk);
        q_valid = 1'b0; q_data = ~qd; q_tag = ~tg;
        if (wr_acc) bank_m[wa] = wd;
        check("accept_in_valid", 64'(in_valid), 64'd1);
        check("accept_query", query, qd);
        check("accept_busy", 64'(busy), 64'd1);
        check("accept_q_ready", 64'(q_ready), 64'd0);
        check_bank("accept");
        wr_en = 1'b0;
        if (wr_busy) begin wr_en = 1'b1; wr_addr = wa; wr_data = ~wd; end
        lat_cnt = 0; iv_cnt = 1;
        while (!r_valid && lat_cnt < 200) begin
            @(negedge clk);
            lat_cnt++;
            if (in_valid) begin
                iv_cnt++;
                check("query_stable", query, qd);
            end
            if (wr_busy && lat_cnt == 1) begin
                check("busy_wr_err_pulse", 64'(wr_err), 64'd1);
                wr_en = 1'b0;
            end
            if (wr_busy && lat_cnt == 2) check("busy_wr_err_end", 64'(wr_err), 64'd0);
        end
        wr_en = 1'b0;
        check("r_valid_seen", 64'(r_valid), 64'd1);
        check("resp_latency", 64'(lat_cnt), 64'(exp_lat));
        check("in_valid_cycles", 64'(iv_cnt), 64'(exp_iv));
        check("r_tag", 64'(r_tag), 64'(tg));
        check("r_addr_1st", 64'(r_addr_1st), 64'(e1));
        check("r_addr_2nd", 64'(r_addr_2nd), 64'(e2));
        check("r_timeout", 64'(r_timeout), 64'(exp_to));
        check("resp_in_valid", 64'(in_valid), 64'd0);
        check("resp_q_ready", 64'(q_ready), 64'd0);
        check_bank("resp");
        q_valid = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_r_valid", 64'(r_valid), 64'd1);
            check("hold_r_fields", {r_tag, r_addr_1st, r_addr_2nd, r_timeout},
                  {tg, e1, e2, exp_to});
            check("hold_q_ready", 64'(q_ready), 64'd0);
            check("hold_no_issue", 64'(in_valid), 64'd0);
        end
        r_ready = 1'b1; q_valid = 1'b0;
        @(negedge clk);
        r_ready = 1'b0;
        check("after_hs_r_valid", 64'(r_valid), 64'd0);
        check("after_hs_q_ready", 64'(q_ready), 64'd1);
        check("after_hs_busy", 64'(busy), 64'd0);
`ifdef DIST_SORT_HOST_STATS_EN
        exp_done++;
        if (exp_to) exp_tmo++;
`endif
    endtask

    task automatic spurious();
        spur_req = 1'b1;
        repeat (3) @(negedge clk);
        check("spur_busy", 64'(busy), 64'd0);
        check("spur_r_valid", 64'(r_valid), 64'd0);
`ifdef DIST_SORT_HOST_STATS_EN
        exp_spur++;
`endif
    endtask

    initial begin
        int lat, w, r;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        q_valid = 1'b0; q_data = '0; q_tag = '0; r_ready = 1'b0;
        for (int k = 0; k < 8; k++) bank_m[k] = '0;
        repeat (3) @(negedge clk);
        check("rst_in_valid", 64'(in_valid), 64'd0);
        check("rst_r_valid", 64'(r_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wr_err", 64'(wr_err), 64'd0);
        check("rst_r_fields", {r_tag, r_addr_1st, r_addr_2nd, r_timeout}, 64'd0);
        check("rst_query", query, 64'd0);
        check_bank("rst");
        rst = 1'b0;
        @(negedge clk);
        check("rst_q_ready", 64'(q_ready), 64'd1);

        // Directed: bank of multiples of 0x1111..., basic answer at latency 5.
        for (int k = 0; k < 8; k++) bank_write(3'(k), 64'h1111_1111_1111_1111 * 64'(k));
        check_bank("bank_init");
        run_query(4'h3, 5, 1, 3'd2, 3'd5, 0, 1'b0, 1'b0, 3'd0);
        // Sorter never answers: watchdog after TIMEOUT issue cycles.
        run_query(4'h9, 0, 1, 3'd1, 3'd6, 0, 1'b0, 1'b0, 3'd0);
        // Answer exactly on the last watchdog cycle still counts.
        run_query(4'h6, int'(TIMEOUT), 1, 3'd7, 3'd3, 0, 1'b0, 1'b0, 3'd0);
        // Stuck out_valid in drain: watchdog aborts drain, addresses kept.
        run_query(4'hA, 4, int'(TIMEOUT) + 1, 3'd4, 3'd1, 0, 1'b0, 1'b0, 3'd0);
        run_query(4'hB, 4, int'(TIMEOUT), 3'd5, 3'd2, 0, 1'b0, 1'b0, 3'd0);
        // Downstream back-pressure with a waiting query.
        run_query(4'hC, 3, 2, 3'd6, 3'd0, 10, 1'b0, 1'b0, 3'd0);
        // Write during ISSUE is dropped; write with accept is taken.
        run_query(4'h5, 6, 1, 3'd3, 3'd4, 0, 1'b1, 1'b0, 3'd4);
        run_query(4'h7, 6, 1, 3'd0, 3'd7, 0, 1'b0, 1'b1, 3'd4);
        spurious();
        spurious();

        // Reset two cycles into ISSUE aborts the query and clears the bank.
        sv_lat = 0;
        wait_ready();
        q_valid = 1'b1; q_data = 64'hDEAD_BEEF_0123_4567; q_tag = 4'h2;
        @(negedge clk);
        q_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_in_valid", 64'(in_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_in_valid", 64'(in_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_r_valid", 64'(r_valid), 64'd0);
        for (int k = 0; k < 8; k++) bank_m[k] = '0;
        check_bank("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_q_ready", 64'(q_ready), 64'd1);
        check("post_rst_r_valid", 64'(r_valid), 64'd0);
        run_query(4'h1, 2, 1, 3'd1, 3'd2, 0, 1'b0, 1'b0, 3'd0);

        // Randomized queries with bank traffic between them.
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 1) == 1)
                bank_write(3'($urandom_range(0, 7)), {$urandom, $urandom});
            r = int'($urandom_range(0, 9));
            if (r == 0) lat = 0;
            else if (r == 1) lat = int'($urandom_range(30, 36));
            else lat = int'($urandom_range(1, 8));
            w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(32, 34))
                                            : int'($urandom_range(1, 3));
            run_query(4'($urandom), lat, w, 3'($urandom), 3'($urandom),
                      int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                      3'($urandom));
        end

`ifdef DIST_SORT_HOST_STATS_EN
        check("stat_done", 64'(stat_done), 64'(exp_done));
        check("stat_timeout", 64'(stat_timeout), 64'(exp_tmo));
        check("stat_spurious", 64'(stat_spurious), 64'(exp_spur));
`endif
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
